// File: rtl/ru_lsu.sv
// Load/store initiator between the execute stage and a word-wide data RAM.
// Byte and halfword stores are done as a read-modify-write, because the RAM only writes whole words.
module ru_lsu #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on the rising edge where req_valid && req_ready.
    // req_ready is high only in IDLE. resp_valid is a single-cycle pulse, and it does not wait for a ready.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT > 0 ? MAX_WAIT - 1 : 0);

    state_t            state, state_next;
    logic [31:0]       addr_q, wdata_q, rdata_q;
    logic [2:0]        funct3_q;
    logic              write_q, err_q;
    logic [CNT_W-1:0]  wait_q;

    logic              bad_funct3, misaligned, req_err, rmw, timeout;
    logic [31:0]       byte_sel, half_sel, load_ext, merged;

    assign bad_funct3 = (req_funct3[1:0] == 2'b11) ||
                        (req_funct3[2] && (req_write || req_funct3[1]));
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign req_err    = bad_funct3 || misaligned;
    assign rmw        = write_q && (funct3_q[1:0] != 2'b10);
    assign timeout    = mem_busy && (MAX_WAIT > 0) && (wait_q == WAIT_LAST);

    assign byte_sel = mem_rdata >> {addr_q[1:0], 3'b000};
    assign half_sel = addr_q[1] ? {16'h0, mem_rdata[31:16]} : {16'h0, mem_rdata[15:0]};

    always_comb begin
        load_ext = mem_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel[7:0]};
            3'b100:  load_ext = {24'h0, byte_sel[7:0]};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel[15:0]};
            3'b101:  load_ext = {16'h0, half_sel[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = mem_rdata;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    // Rejected requests spend one cycle in RD with err_q set and do not access the RAM.
    // This gives them the same two-cycle response time as a load.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (req_valid)
                        state_next = (req_write && !req_err && req_funct3[1:0] == 2'b10) ? S_WR : S_RD;
            S_RD:   if (err_q || timeout)  state_next = S_RESP;
                    else if (!mem_busy)    state_next = rmw ? S_WR : S_RESP;
            S_WR:   if (!mem_busy || timeout) state_next = S_RESP;
            S_RESP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wait_q   <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: if (req_valid) begin
                    addr_q   <= req_addr;
                    wdata_q  <= req_wdata;
                    funct3_q <= req_funct3;
                    write_q  <= req_write;
                    rdata_q  <= '0;
                    err_q    <= req_err;
                    wait_q   <= '0;
                end
                S_RD: if (!err_q) begin
                    if (!mem_busy) begin
                        if (rmw) begin
                            wdata_q <= merged;
                            wait_q  <= '0;
                        end else begin
                            rdata_q <= load_ext;
                        end
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_WR: if (mem_busy) begin
                    if (timeout) err_q  <= 1'b1;
                    else         wait_q <= wait_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = (state == S_RESP) ? rdata_q : 32'h0;
    assign resp_err   = (state == S_RESP) && err_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_we     = (state == S_WR);
    assign mem_wdata  = (state == S_WR) ? wdata_q : 32'h0;
    assign dbg_state  = state;

endmodule

// File: tb/tb_ru_lsu.sv
// Directed and randomized bench for ru_lsu against a 64-word RAM model.
// A byte-level reference model in the bench produces every expected value.
module tb_ru_lsu;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_busy = 1'b0;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    ru_lsu #(.MAX_WAIT(MAX_WAIT), .CNT_W(3)) dut (
        .clk(clk), .nRst(nRst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read; writes commit on the edge where mem_we && !mem_busy.
    logic [31:0] ram [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;
    int          commits = 0;

    always_comb mem_rdata = ram[mem_addr[7:2]];

    always @(posedge clk) begin
        if (pl_en) ram[pl_idx] <= pl_val;
        else if (mem_we && !mem_busy) begin
            ram[mem_addr[7:2]] <= mem_wdata;
            commits <= commits + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Reference model. It works on bytes at the level of the instruction set, and it counts latency in cycles after the accept edge.
    function automatic void ref_model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [31:0] w, input int busy,
                                      output logic e_err, output logic [31:0] e_rd, output logic [31:0] e_word,
                                      output int e_lat, output logic e_we, output int e_commit);
        int size, off;
        logic bad;
        logic [31:0] v;
        size = 1 << f3[1:0];
        off = int'(a % 4);
        bad = (f3[1:0] == 2'b11) || (f3[2] && (wr || f3[1])) || ((a % size) != 0);
        e_word = w; e_rd = '0; e_commit = 0; e_we = 1'b0; e_err = 1'b0;
        if (bad) begin
            e_err = 1'b1; e_lat = 2;
        end else if (busy >= MAX_WAIT) begin
            e_err = 1'b1; e_lat = MAX_WAIT + 1; e_we = wr && (size == 4);
        end else begin
            e_lat = busy + ((wr && size < 4) ? 3 : 2);
            if (wr) begin
                for (int i = 0; i < size; i++) e_word[(off + i) * 8 +: 8] = wd[i * 8 +: 8];
                e_we = 1'b1; e_commit = 1;
            end else begin
                v = w >> (8 * off);
                if (size == 1)      v = f3[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
                else if (size == 2) v = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
                e_rd = v;
            end
        end
    endfunction

    logic [31:0] got_rdata, got_we_data;

    task automatic run_req(input string tag, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int busy);
        logic e_err, e_we, saw_we, got, g_err;
        logic [31:0] e_rd, e_word, w0, we_addr;
        int e_lat, e_commit, c0, cyc;
        w0 = ram[a[7:2]];
        c0 = commits;
        ref_model(wr, f3, a, wd, w0, busy, e_err, e_rd, e_word, e_lat, e_we, e_commit);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        mem_busy = (busy > 0);
        cyc = 0; got = 1'b0; saw_we = 1'b0; g_err = 1'b0;
        got_rdata = '0; got_we_data = '0; we_addr = '0;
        while (!got && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (mem_we) begin
                saw_we = 1'b1; got_we_data = mem_wdata; we_addr = mem_addr;
            end
            if (resp_valid) begin
                got = 1'b1; got_rdata = resp_rdata; g_err = resp_err;
            end
            if (cyc == busy + 1) mem_busy = 1'b0;
        end
        mem_busy = 1'b0;
        chk({tag, "_resp_seen"}, {31'h0, got}, 32'h1);
        chk({tag, "_latency"}, cyc, e_lat);
        chk({tag, "_err"}, {31'h0, g_err}, {31'h0, e_err});
        chk({tag, "_rdata"}, got_rdata, e_rd);
        chk({tag, "_we_seen"}, {31'h0, saw_we}, {31'h0, e_we});
        chk({tag, "_commits"}, commits - c0, e_commit);
        chk({tag, "_ram_word"}, ram[a[7:2]], e_word);
        if (e_commit == 1) begin
            chk({tag, "_wdata"}, got_we_data, e_word);
            chk({tag, "_waddr"}, we_addr, {a[31:2], 2'b00});
        end
    endtask

    initial begin
        logic [31:0] w0;
        logic saw;
        int c0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        nRst = 1'b1;

        for (int i = 0; i < 64; i++) poke(6'(i), $urandom);

        // Word round trip
        run_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
        run_req("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 0);
        chk("lw10_const", got_rdata, 32'hDEADBEEF);

        // Sub-word load extension
        poke(6'd8, 32'h80F07F01);
        run_req("lb23", 1'b0, 3'b000, 32'h23, 32'h0, 0);
        chk("lb23_const", got_rdata, 32'hFFFFFF80);
        run_req("lbu23", 1'b0, 3'b100, 32'h23, 32'h0, 0);
        chk("lbu23_const", got_rdata, 32'h00000080);
        run_req("lh22", 1'b0, 3'b001, 32'h22, 32'h0, 0);
        chk("lh22_const", got_rdata, 32'hFFFF80F0);
        run_req("lhu20", 1'b0, 3'b101, 32'h20, 32'h0, 0);
        chk("lhu20_const", got_rdata, 32'h00007F01);

        // Read-modify-write stores
        poke(6'd12, 32'h11223344);
        run_req("sb31", 1'b1, 3'b000, 32'h31, 32'h000000AA, 0);
        chk("sb31_const", got_we_data, 32'h1122AA44);
        run_req("sh32", 1'b1, 3'b001, 32'h32, 32'h0000BEEF, 0);
        chk("sh32_const", ram[12], 32'hBEEFAA44);

        // Rejected requests
        run_req("lw41", 1'b0, 3'b010, 32'h41, 32'h0, 0);
        run_req("sh43", 1'b1, 3'b001, 32'h43, 32'h1234, 0);
        run_req("f3_011", 1'b0, 3'b011, 32'h40, 32'h0, 0);

        // Busy cycles and timeout
        run_req("lw_busy3", 1'b0, 3'b010, 32'h10, 32'h0, 3);
        chk("lw_busy3_const", got_rdata, 32'hDEADBEEF);
        run_req("sw_tmo", 1'b1, 3'b010, 32'h10, 32'h12345678, 6);
        chk("sw_tmo_const", ram[4], 32'hDEADBEEF);
        run_req("sb_tmo", 1'b1, 3'b000, 32'h31, 32'h00000055, 5);

        // Reset during the write phase of a byte store
        poke(6'd20, 32'hCAFEF00D);
        w0 = ram[20];
        c0 = commits;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h51; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_we_before", {31'h0, mem_we}, 32'h1);
        mem_busy = 1'b1;
        #2 nRst = 1'b0;
        #1;
        chk("rst_mid_we_after", {31'h0, mem_we}, 32'h0);
        chk("rst_mid_state", {30'h0, dbg_state}, 32'h0);
        @(negedge clk);
        nRst = 1'b1; mem_busy = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw = saw | resp_valid;
        end
        chk("rst_mid_no_resp", {31'h0, saw}, 32'h0);
        chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_mid_ram", ram[20], w0);
        chk("rst_mid_commits", commits - c0, 0);

        // Randomized requests
        for (int n = 0; n < 60; n++) begin
            logic [2:0] f3;
            int r, busy;
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                r = $urandom_range(0, 4);
                f3 = (r == 0) ? 3'b000 : (r == 1) ? 3'b001 : (r == 2) ? 3'b010 : (r == 3) ? 3'b100 : 3'b101;
            end
            r = $urandom_range(0, 9);
            busy = (r < 6) ? 0 : (r < 9) ? r - 5 : 5;
            run_req("rand", 1'($urandom_range(0, 1)), f3, 32'($urandom_range(0, 255)), $urandom, busy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
